// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: bus widths,
// requester ids, lock state encodings and the round-robin pick.
package dmem_arb_pkg;

   // Bus widths of the data-memory port
   localparam int SIZE_ADDR = 16;
   localparam int HBIT_ADDR = SIZE_ADDR - 1;
   localparam int SIZE_DATA = 32;
   localparam int HBIT_DATA = SIZE_DATA - 1;

   // Requester ids (also the id carried through the read tag line)
   localparam logic ARB_ID_CORE   = 1'b0;
   localparam logic ARB_ID_LOADER = 1'b1;

   // Lock state encodings (only used when the lock feature is built in)
   typedef enum logic [1:0] {
      ARB_ST_IDLE  = 2'd0,
      ARB_ST_LOCK0 = 2'd1,
      ARB_ST_LOCK1 = 2'd2
   } arb_state_t;

   // One entry of the read tag line: a read is in flight for requester id
   typedef struct packed {
      logic valid;
      logic id;
   } arb_tag_t;

   // Round-robin pick between two eligible requesters.
   // Returns {grant1, grant0}; on a tie the requester that did not win last time wins.
   function automatic logic [1:0] arb_rr_pick(input logic elig0,
                                              input logic elig1,
                                              input logic last_id);
      logic [1:0] pick;
      pick = 2'b00;
      if (elig0 && elig1) begin
         pick = (last_id == ARB_ID_CORE) ? 2'b10 : 2'b01;
      end else if (elig0) begin
         pick = 2'b01;
      end else if (elig1) begin
         pick = 2'b10;
      end
      return pick;
   endfunction

endpackage

// File: rtl/dmem_arb_rdtag.sv
// Read tag delay line: RD_LAT stages of {valid,id}. A tag pushed on the issue
// edge reaches the output exactly when the memory read data for it is valid.
// Asynchronous clear drops every in-flight read.
module dmem_arb_rdtag
   import dmem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic iw_clk,
   input  logic iw_rst,
   input  logic iw_push_valid,
   input  logic iw_push_id,
   output logic ow_pop_valid,
   output logic ow_pop_id
);

   arb_tag_t [RD_LAT-1:0] stage_reg;

   // Shift the tag line by one stage every cycle; empty slots carry valid=0
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         stage_reg <= '0;
      end else begin
         stage_reg[0] <= '{valid: iw_push_valid, id: iw_push_id};
         for (int i = 1; i < RD_LAT; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign ow_pop_valid = stage_reg[RD_LAT-1].valid;
   assign ow_pop_id    = stage_reg[RD_LAT-1].id;

endmodule

// File: rtl/dmem_arb.sv
// Two-requester round-robin arbiter for one data-memory port.
// Requester 0 is the core MA/MO stages, requester 1 the loader/debug master.
// Read responses are routed back in order through a tag delay line, and a
// saturating counter records cycles in which a valid requester was refused.
// Optional feature: define MEM_ARB_LOCK_EN to add lock ports and the
// IDLE/LOCK0/LOCK1 grant-hold FSM with forced release after LOCK_MAX cycles.
module dmem_arb
   import dmem_arb_pkg::*;
#(
   parameter int RD_LAT   = 1,
   parameter int CNT_W    = 16,
   parameter int LOCK_MAX = 8
) (
   input  logic                 iw_clk,
   input  logic                 iw_rst,
   input  logic                 iw_req0_valid,
   output logic                 ow_req0_ready,
   input  logic                 iw_req0_we,
   input  logic [HBIT_ADDR:0]   iw_req0_addr,
   input  logic [HBIT_DATA:0]   iw_req0_wdata,
   input  logic                 iw_req1_valid,
   output logic                 ow_req1_ready,
   input  logic                 iw_req1_we,
   input  logic [HBIT_ADDR:0]   iw_req1_addr,
   input  logic [HBIT_DATA:0]   iw_req1_wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic                 iw_req0_lock,
   input  logic                 iw_req1_lock,
`endif
   output logic                 or_rsp0_valid,
   output logic [HBIT_DATA:0]   or_rsp0_rdata,
   output logic                 or_rsp1_valid,
   output logic [HBIT_DATA:0]   or_rsp1_rdata,
   output logic                 ow_mem_we,
   output logic [HBIT_ADDR:0]   ow_mem_addr,
   output logic [HBIT_DATA:0]   ow_mem_wdata,
   input  logic [HBIT_DATA:0]   iw_mem_rdata,
   output logic [CNT_W-1:0]     or_conflict_cnt
);

   logic       last_grant_reg;
   logic       allow0;
   logic       allow1;
   logic       grant0;
   logic       grant1;
   logic       issue0;
   logic       issue1;
   logic       force_rel;
   logic       force_id;
   logic       conflict;
   logic       push_valid;
   logic       pop_valid;
   logic       pop_id;

`ifdef MEM_ARB_LOCK_EN
   localparam int LK_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   arb_state_t       state_reg;
   arb_state_t       state_next;
   logic [LK_W-1:0]  lock_cnt_reg;
   logic [LK_W-1:0]  lock_cnt_next;

   // Lock state register and cycles-spent-in-lock counter
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state_reg    <= ARB_ST_IDLE;
         lock_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         lock_cnt_reg <= lock_cnt_next;
      end
   end

   // Next lock state: enter on a locking issue, leave on an unlocking issue by
   // the owner or after LOCK_MAX cycles (forced, hands the next tie to the other side)
   always_comb begin
      state_next    = state_reg;
      lock_cnt_next = '0;
      force_rel     = 1'b0;
      force_id      = ARB_ID_CORE;
      case (state_reg)
         ARB_ST_IDLE: begin
            if (issue0 && iw_req0_lock) begin
               state_next = ARB_ST_LOCK0;
            end else if (issue1 && iw_req1_lock) begin
               state_next = ARB_ST_LOCK1;
            end
         end
         ARB_ST_LOCK0: begin
            if (issue0 && !iw_req0_lock) begin
               state_next = ARB_ST_IDLE;
            end else if (lock_cnt_reg == LK_W'(LOCK_MAX - 1)) begin
               state_next = ARB_ST_IDLE;
               force_rel  = 1'b1;
               force_id   = ARB_ID_CORE;
            end else begin
               lock_cnt_next = lock_cnt_reg + 1'b1;
            end
         end
         ARB_ST_LOCK1: begin
            if (issue1 && !iw_req1_lock) begin
               state_next = ARB_ST_IDLE;
            end else if (lock_cnt_reg == LK_W'(LOCK_MAX - 1)) begin
               state_next = ARB_ST_IDLE;
               force_rel  = 1'b1;
               force_id   = ARB_ID_LOADER;
            end else begin
               lock_cnt_next = lock_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ARB_ST_IDLE;
         end
      endcase
   end

   // Lock outputs: while a lock is held only its owner is eligible
   always_comb begin
      allow0 = (state_reg != ARB_ST_LOCK1);
      allow1 = (state_reg != ARB_ST_LOCK0);
   end
`else
   logic unused_lock_cfg;

   assign unused_lock_cfg = (LOCK_MAX > 0);
   assign allow0          = 1'b1;
   assign allow1          = 1'b1;
   assign force_rel       = 1'b0;
   assign force_id        = ARB_ID_CORE;
`endif

   // Grant: round-robin among the eligible valid requesters
   always_comb begin
      {grant1, grant0} = arb_rr_pick(iw_req0_valid && allow0,
                                     iw_req1_valid && allow1,
                                     last_grant_reg);
   end

   assign ow_req0_ready = grant0;
   assign ow_req1_ready = grant1;
   assign issue0        = iw_req0_valid && grant0;
   assign issue1        = iw_req1_valid && grant1;

   // Memory port driven by the issuing request, all-zero when idle
   always_comb begin
      ow_mem_we    = 1'b0;
      ow_mem_addr  = '0;
      ow_mem_wdata = '0;
      if (issue0) begin
         ow_mem_we    = iw_req0_we;
         ow_mem_addr  = iw_req0_addr;
         ow_mem_wdata = iw_req0_wdata;
      end else if (issue1) begin
         ow_mem_we    = iw_req1_we;
         ow_mem_addr  = iw_req1_addr;
         ow_mem_wdata = iw_req1_wdata;
      end
   end

   // Last-grant register: follows issues; a forced lock release points it at the old owner
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         last_grant_reg <= ARB_ID_LOADER;
      end else if (issue0) begin
         last_grant_reg <= ARB_ID_CORE;
      end else if (issue1) begin
         last_grant_reg <= ARB_ID_LOADER;
      end else if (force_rel) begin
         last_grant_reg <= force_id;
      end
   end

   assign push_valid = (issue0 && !iw_req0_we) || (issue1 && !iw_req1_we);

   dmem_arb_rdtag #(
      .RD_LAT (RD_LAT)
   ) u_rdtag (
      .iw_clk        (iw_clk),
      .iw_rst        (iw_rst),
      .iw_push_valid (push_valid),
      .iw_push_id    (issue1),
      .ow_pop_valid  (pop_valid),
      .ow_pop_id     (pop_id)
   );

   // Response registers: capture read data for the requester at the end of the tag line
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         or_rsp0_valid <= 1'b0;
         or_rsp1_valid <= 1'b0;
         or_rsp0_rdata <= '0;
         or_rsp1_rdata <= '0;
      end else begin
         or_rsp0_valid <= pop_valid && (pop_id == ARB_ID_CORE);
         or_rsp1_valid <= pop_valid && (pop_id == ARB_ID_LOADER);
         if (pop_valid && (pop_id == ARB_ID_CORE)) begin
            or_rsp0_rdata <= iw_mem_rdata;
         end
         if (pop_valid && (pop_id == ARB_ID_LOADER)) begin
            or_rsp1_rdata <= iw_mem_rdata;
         end
      end
   end

   assign conflict = (iw_req0_valid && !grant0) || (iw_req1_valid && !grant1);

   // Contention counter: one count per cycle with any refusal, sticks at all-ones
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         or_conflict_cnt <= '0;
      end else if (conflict && (or_conflict_cnt != {CNT_W{1'b1}})) begin
         or_conflict_cnt <= or_conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb (RD_LAT=1, CNT_W=4). Build with MEM_ARB_LOCK_EN
// defined to also exercise the lock hold and forced release.
module tb_dmem_arb;
   import dmem_arb_pkg::*;

   localparam int RD_LAT   = 1;
   localparam int CNT_W    = 4;
   localparam int LOCK_MAX = 8;

   logic                iw_clk = 1'b0;
   logic                iw_rst;
   logic                iw_req0_valid, iw_req1_valid;
   logic                ow_req0_ready, ow_req1_ready;
   logic                iw_req0_we, iw_req1_we;
   logic [HBIT_ADDR:0]  iw_req0_addr, iw_req1_addr;
   logic [HBIT_DATA:0]  iw_req0_wdata, iw_req1_wdata;
   logic                iw_req0_lock, iw_req1_lock;
   logic                or_rsp0_valid, or_rsp1_valid;
   logic [HBIT_DATA:0]  or_rsp0_rdata, or_rsp1_rdata;
   logic                ow_mem_we;
   logic [HBIT_ADDR:0]  ow_mem_addr;
   logic [HBIT_DATA:0]  ow_mem_wdata;
   logic [HBIT_DATA:0]  iw_mem_rdata;
   logic [CNT_W-1:0]    or_conflict_cnt;

   logic [HBIT_DATA:0]  mem [256];

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 iw_clk = ~iw_clk;

   dmem_arb #(
      .RD_LAT   (RD_LAT),
      .CNT_W    (CNT_W),
      .LOCK_MAX (LOCK_MAX)
   ) dut (
      .iw_clk          (iw_clk),
      .iw_rst          (iw_rst),
      .iw_req0_valid   (iw_req0_valid),
      .ow_req0_ready   (ow_req0_ready),
      .iw_req0_we      (iw_req0_we),
      .iw_req0_addr    (iw_req0_addr),
      .iw_req0_wdata   (iw_req0_wdata),
      .iw_req1_valid   (iw_req1_valid),
      .ow_req1_ready   (ow_req1_ready),
      .iw_req1_we      (iw_req1_we),
      .iw_req1_addr    (iw_req1_addr),
      .iw_req1_wdata   (iw_req1_wdata),
`ifdef MEM_ARB_LOCK_EN
      .iw_req0_lock    (iw_req0_lock),
      .iw_req1_lock    (iw_req1_lock),
`endif
      .or_rsp0_valid   (or_rsp0_valid),
      .or_rsp0_rdata   (or_rsp0_rdata),
      .or_rsp1_valid   (or_rsp1_valid),
      .or_rsp1_rdata   (or_rsp1_rdata),
      .ow_mem_we       (ow_mem_we),
      .ow_mem_addr     (ow_mem_addr),
      .ow_mem_wdata    (ow_mem_wdata),
      .iw_mem_rdata    (iw_mem_rdata),
      .or_conflict_cnt (or_conflict_cnt)
   );

   // Single-port synchronous memory, one-cycle read latency
   always @(posedge iw_clk) begin
      if (ow_mem_we) mem[ow_mem_addr[7:0]] <= ow_mem_wdata;
      iw_mem_rdata <= mem[ow_mem_addr[7:0]];
   end

   // One line per issued transaction
   always @(posedge iw_clk) begin
      if (!iw_rst && iw_req0_valid && ow_req0_ready)
         $display("txn req0 %s addr=0x%0h wdata=0x%0h", iw_req0_we ? "wr" : "rd", iw_req0_addr, iw_req0_wdata);
      if (!iw_rst && iw_req1_valid && ow_req1_ready)
         $display("txn req1 %s addr=0x%0h wdata=0x%0h", iw_req1_we ? "wr" : "rd", iw_req1_addr, iw_req1_wdata);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge iw_clk);
      #2;
   endtask

   task automatic idle_reqs();
      iw_req0_valid = 1'b0; iw_req0_we = 1'b0; iw_req0_addr = '0; iw_req0_wdata = '0; iw_req0_lock = 1'b0;
      iw_req1_valid = 1'b0; iw_req1_we = 1'b0; iw_req1_addr = '0; iw_req1_wdata = '0; iw_req1_lock = 1'b0;
   endtask

   task automatic apply_reset();
      iw_rst = 1'b1;
      idle_reqs();
      tick();
      tick();
      iw_rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'hA5;
      mem[8'h30] = 32'h33;
      mem[8'h40] = 32'h44;

      // ---- reset state and single read by req0 ----
      apply_reset();
      #1;
      check_val("rst_rsp0_valid", or_rsp0_valid, 0);
      check_val("rst_rsp1_valid", or_rsp1_valid, 0);
      check_val("rst_rsp0_rdata", or_rsp0_rdata, 0);
      check_val("rst_cnt", or_conflict_cnt, 0);
      check_val("rst_mem_addr", ow_mem_addr, 0);
      check_val("rst_ready0", ow_req0_ready, 0);
      iw_req0_valid = 1'b1; iw_req0_addr = 16'h10;
      #1;
      check_val("rd_ready0", ow_req0_ready, 1);
      check_val("rd_mem_addr", ow_mem_addr, 32'h10);
      check_val("rd_mem_we", ow_mem_we, 0);
      tick();
      iw_req0_valid = 1'b0;
      #1;
      check_val("rd_rsp0_early", or_rsp0_valid, 0);
      tick(); #1;
      check_val("rd_rsp0_valid", or_rsp0_valid, 1);
      check_val("rd_rsp0_rdata", or_rsp0_rdata, 32'hA5);
      check_val("rd_rsp1_valid", or_rsp1_valid, 0);
      tick(); #1;
      check_val("rd_rsp0_pulse_end", or_rsp0_valid, 0);
      check_val("rd_rsp0_hold", or_rsp0_rdata, 32'hA5);

      // ---- both requesters read, held 6 cycles ----
      apply_reset();
      iw_req0_valid = 1'b1; iw_req0_addr = 16'h30;
      iw_req1_valid = 1'b1; iw_req1_addr = 16'h40;
      for (int j = 0; j < 8; j++) begin
         if (j == 6) begin
            iw_req0_valid = 1'b0;
            iw_req1_valid = 1'b0;
         end
         #1;
         if (j < 6) begin
            check_val($sformatf("rr_ready0_c%0d", j), ow_req0_ready, (j % 2) == 0);
            check_val($sformatf("rr_ready1_c%0d", j), ow_req1_ready, (j % 2) == 1);
         end
         if (j >= 2) begin
            check_val($sformatf("rr_rsp0_c%0d", j), or_rsp0_valid, (j % 2) == 0);
            check_val($sformatf("rr_rsp1_c%0d", j), or_rsp1_valid, (j % 2) == 1);
         end
         if (j == 6) check_val("rr_cnt", or_conflict_cnt, 6);
         tick();
      end
      #1;
      check_val("rr_rsp0_rdata", or_rsp0_rdata, 32'h33);
      check_val("rr_rsp1_rdata", or_rsp1_rdata, 32'h44);
      check_val("rr_cnt_idle", or_conflict_cnt, 6);

      // ---- req1 writes 0x20, req0 reads it back the next cycle ----
      iw_req1_valid = 1'b1; iw_req1_we = 1'b1; iw_req1_addr = 16'h20; iw_req1_wdata = 32'h5A;
      #1;
      check_val("wr_ready1", ow_req1_ready, 1);
      check_val("wr_mem_we", ow_mem_we, 1);
      check_val("wr_mem_wdata", ow_mem_wdata, 32'h5A);
      tick();
      iw_req1_valid = 1'b0; iw_req1_we = 1'b0;
      iw_req0_valid = 1'b1; iw_req0_addr = 16'h20;
      #1;
      check_val("wr_rd_ready0", ow_req0_ready, 1);
      check_val("wr_no_rsp1", or_rsp1_valid, 0);
      tick();
      iw_req0_valid = 1'b0;
      #1;
      check_val("wr_no_rsp1_b", or_rsp1_valid, 0);
      tick(); #1;
      check_val("wr_rd_rsp0_valid", or_rsp0_valid, 1);
      check_val("wr_rd_rsp0_rdata", or_rsp0_rdata, 32'h5A);
      tick();

      // ---- reset with two reads in flight ----
      iw_req0_valid = 1'b1; iw_req0_addr = 16'h10;
      tick();
      iw_req0_valid = 1'b0;
      iw_req1_valid = 1'b1; iw_req1_addr = 16'h40;
      tick();
      iw_req1_valid = 1'b0;
      iw_rst = 1'b1;
      #1;
      check_val("mrst_rsp0", or_rsp0_valid, 0);
      check_val("mrst_cnt", or_conflict_cnt, 0);
      tick();
      tick();
      iw_rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_val($sformatf("mrst_rsp0_c%0d", k), or_rsp0_valid, 0);
         check_val($sformatf("mrst_rsp1_c%0d", k), or_rsp1_valid, 0);
         tick();
      end
      iw_req0_valid = 1'b1; iw_req0_addr = 16'h10;
      iw_req1_valid = 1'b1; iw_req1_addr = 16'h40;
      #1;
      check_val("mrst_tie_ready0", ow_req0_ready, 1);
      check_val("mrst_tie_ready1", ow_req1_ready, 0);
      tick();

      // ---- counter saturation under continuous dual demand ----
      for (int i = 0; i < 19; i++) begin
         #1;
         check_val($sformatf("sat_cnt_c%0d", i), or_conflict_cnt, (1 + i > 15) ? 15 : 1 + i);
         tick();
      end
      iw_req0_valid = 1'b0;
      iw_req1_valid = 1'b0;
      #1;
      check_val("sat_cnt_final", or_conflict_cnt, 4'hF);
      tick();

`ifdef MEM_ARB_LOCK_EN
      // ---- lock held by req0, released by an unlocking issue ----
      apply_reset();
      iw_req0_valid = 1'b1; iw_req0_addr = 16'h10; iw_req0_lock = 1'b1;
      iw_req1_valid = 1'b1; iw_req1_addr = 16'h40;
      #1;
      check_val("lk_ready0", ow_req0_ready, 1);
      tick();
      iw_req0_valid = 1'b0; iw_req0_lock = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         check_val($sformatf("lk_hold_ready1_c%0d", k), ow_req1_ready, 0);
         tick();
      end
      iw_req0_valid = 1'b1;
      #1;
      check_val("lk_rel_ready0", ow_req0_ready, 1);
      check_val("lk_rel_ready1", ow_req1_ready, 0);
      tick();
      iw_req0_valid = 1'b0;
      #1;
      check_val("lk_after_ready1", ow_req1_ready, 1);
      tick();
      iw_req1_valid = 1'b0;

      // ---- lock never released: forced release after LOCK_MAX cycles ----
      iw_req0_valid = 1'b1; iw_req0_lock = 1'b1;
      #1;
      check_val("fr_ready0", ow_req0_ready, 1);
      tick();
      iw_req0_valid = 1'b0; iw_req0_lock = 1'b0;
      iw_req1_valid = 1'b1;
      for (int k = 1; k <= LOCK_MAX; k++) begin
         #1;
         check_val($sformatf("fr_hold_ready1_c%0d", k), ow_req1_ready, 0);
         tick();
      end
      #1;
      check_val("fr_free_ready1", ow_req1_ready, 1);
      tick();
      iw_req1_valid = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
